// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared UART definitions: receiver/transmitter state encoding
//                and frame data width.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    localparam int DATA_BITS = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

endpackage
`default_nettype wire

// File: rtl/uart_rx_sync.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_sync
//  Description : Two-flop synchronizer (resets to 1, idle line) with a
//                falling-edge pulse. The edge detector only arms once the
//                pipeline holds real samples and a high level has been seen,
//                so a line already low at reset release never fakes an edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_sync (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic sync_out,
    output logic fall
);

    logic       meta;
    logic       sync;
    logic       prev;
    logic [1:0] fill;
    logic       primed;

    assign primed   = (fill == 2'd2);
    assign sync_out = sync;
    assign fall     = primed & prev & ~sync;

    // Double-register the asynchronous input; both stages idle high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= 1'b1;
            sync <= 1'b1;
        end else begin
            meta <= async_in;
            sync <= meta;
        end
    end

    // Track the previous synchronized level once the reset values have flushed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fill <= 2'd0;
            prev <= 1'b0;
        end else if (!primed) begin
            fill <= fill + 2'd1;
        end else begin
            prev <= sync;
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx
//  Description : 8N1 UART receiver with a valid/ready holding register and
//                framing / overrun error pulses.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_rx #(
    parameter int CLKS_PER_BIT = 434,
    parameter int DATA_BITS    = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 overrun_err,
    output logic                 busy
);
    import uart_pkg::*;

    localparam int            CW      = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_TC = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_TC = CW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]    LAST_IX = 3'(DATA_BITS - 1);

    uart_state_t          state;
    uart_state_t          state_nxt;
    logic [CW-1:0]        cnt;
    logic [2:0]           bit_idx;
    logic [DATA_BITS-1:0] shreg;
    logic                 rx_s;
    logic                 fall;
    logic                 tc_half;
    logic                 tc_full;
    logic                 cnt_clr;
    logic                 idx_clr;
    logic                 shift_en;
    logic                 load_byte;
    logic                 frame_bad;

    uart_rx_sync u_sync (
        .clk      (clk),
        .rst      (rst),
        .async_in (rx),
        .sync_out (rx_s),
        .fall     (fall)
    );

    assign tc_half = (cnt == HALF_TC);
    assign tc_full = (cnt == FULL_TC);
    assign busy    = (state != IDLE);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode and per-cycle datapath controls.
    always_comb begin
        state_nxt = state;
        cnt_clr   = 1'b0;
        idx_clr   = 1'b0;
        shift_en  = 1'b0;
        load_byte = 1'b0;
        frame_bad = 1'b0;
        case (state)
            IDLE: begin
                if (fall) begin
                    cnt_clr   = 1'b1;
                    state_nxt = START;
                end
            end
            START: begin
                if (tc_half) begin
                    cnt_clr   = 1'b1;
                    idx_clr   = 1'b1;
                    state_nxt = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (tc_full) begin
                    cnt_clr  = 1'b1;
                    shift_en = 1'b1;
                    if (bit_idx == LAST_IX) begin
                        state_nxt = STOP;
                    end
                end
            end
            STOP: begin
                if (tc_full) begin
                    cnt_clr   = 1'b1;
                    state_nxt = IDLE;
                    load_byte = rx_s;
                    frame_bad = ~rx_s;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Baud counter, bit index and LSB-first shift register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt     <= '0;
            bit_idx <= 3'd0;
            shreg   <= '0;
        end else begin
            if (cnt_clr || state == IDLE) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
            if (idx_clr) begin
                bit_idx <= 3'd0;
            end else if (shift_en) begin
                shreg[bit_idx] <= rx_s;
                bit_idx        <= bit_idx + 3'd1;
            end
        end
    end

    // Output holding register: load, accept, overrun and framing pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            frame_err   <= 1'b0;
            overrun_err <= 1'b0;
        end else begin
            frame_err   <= frame_bad;
            overrun_err <= load_byte & rx_valid & ~rx_ready;
            if (load_byte) begin
                rx_data  <= shreg;
                rx_valid <= 1'b1;
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_rx
//  Description : Directed self-checking bench for uart_rx (CLKS_PER_BIT=16
//                and a second instance at CLKS_PER_BIT=5).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx = 1'b1;
    logic       rx_ready = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid, frame_err, overrun_err, busy;

    logic       rx5 = 1'b1;
    logic       rx_ready5 = 1'b0;
    logic [7:0] rx_data5;
    logic       rx_valid5, frame_err5, overrun_err5, busy5;

    int n_checks = 0;
    int n_errors = 0;
    int fe_cnt = 0, ov_cnt = 0, busy_cnt = 0;
    int fe5_cnt = 0, ov5_cnt = 0;
    int lat;

    uart_rx #(.CLKS_PER_BIT(16), .DATA_BITS(8)) u_dut (
        .clk(clk), .rst(rst), .rx(rx), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ready(rx_ready), .frame_err(frame_err), .overrun_err(overrun_err), .busy(busy)
    );

    uart_rx #(.CLKS_PER_BIT(5), .DATA_BITS(8)) u_dut5 (
        .clk(clk), .rst(rst), .rx(rx5), .rx_data(rx_data5), .rx_valid(rx_valid5),
        .rx_ready(rx_ready5), .frame_err(frame_err5), .overrun_err(overrun_err5), .busy(busy5)
    );

    always #5 clk = ~clk;

    // Pulse/activity counters sampled 1 ns after each rising edge.
    always @(posedge clk) begin
        #1;
        if (frame_err)    fe_cnt++;
        if (overrun_err)  ov_cnt++;
        if (busy)         busy_cnt++;
        if (frame_err5)   fe5_cnt++;
        if (overrun_err5) ov5_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Drive one frame starting at the current falling clock edge.
    task automatic send_frame(input bit sel5, input logic [7:0] b, input bit stop_v, input bit jit);
        int         cpb;
        int         len;
        logic [9:0] bits;
        int         jv[10];
        cpb  = sel5 ? 5 : 16;
        bits = {stop_v, b, 1'b0};
        jv   = '{1, -1, -1, 1, 0, 1, -1, 0, -1, 1};
        for (int i = 0; i < 10; i++) begin
            if (sel5) rx5 = bits[i];
            else      rx  = bits[i];
            len = cpb + (jit ? jv[i] : 0);
            repeat (len) @(negedge clk);
        end
    endtask

    task automatic pulse_ready;
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        check("reset_valid", rx_valid, 0);
        check("reset_data", rx_data, 8'h00);
        check("reset_busy", busy, 0);
        check("reset_ferr", frame_err, 0);
        check("reset_oerr", overrun_err, 0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // 1: frame 0x55, held until accepted
        fe_cnt = 0; ov_cnt = 0; lat = 0;
        fork
            send_frame(1'b0, 8'h55, 1'b1, 1'b0);
            begin
                while (!rx_valid && lat < 200) begin
                    @(negedge clk);
                    lat++;
                end
            end
        join
        check("t1_latency", lat, 155);
        check("t1_data", rx_data, 8'h55);
        repeat (20) @(negedge clk);
        check("t1_valid_held", rx_valid, 1);
        check("t1_ferr", fe_cnt, 0);
        check("t1_oerr", ov_cnt, 0);
        pulse_ready();
        check("t1_valid_cleared", rx_valid, 0);

        // 2: 4-clk low glitch
        repeat (10) @(negedge clk);
        busy_cnt = 0;
        rx = 1'b0;
        repeat (4) @(negedge clk);
        rx = 1'b1;
        repeat (10) @(negedge clk);
        check("t2_started", busy_cnt != 0, 1);
        check("t2_busy_idle", busy, 0);
        check("t2_valid", rx_valid, 0);
        check("t2_ferr", fe_cnt, 0);

        // 3: 0xA3 with low stop bit, then break
        repeat (10) @(negedge clk);
        fe_cnt = 0;
        send_frame(1'b0, 8'hA3, 1'b0, 1'b0);
        busy_cnt = 0;
        repeat (100) @(negedge clk);
        check("t3_ferr_pulse", fe_cnt, 1);
        check("t3_valid", rx_valid, 0);
        check("t3_break_idle", busy_cnt, 0);
        rx = 1'b1;
        repeat (40) @(negedge clk);
        check("t3_no_retrigger", busy_cnt, 0);
        check("t3_valid_after", rx_valid, 0);

        // 4a: back-to-back with no accept -> overrun
        ov_cnt = 0; fe_cnt = 0;
        send_frame(1'b0, 8'h11, 1'b1, 1'b0);
        send_frame(1'b0, 8'h22, 1'b1, 1'b0);
        repeat (4) @(negedge clk);
        check("t4_data", rx_data, 8'h22);
        check("t4_valid", rx_valid, 1);
        check("t4_overrun", ov_cnt, 1);
        pulse_ready();
        check("t4_accept", rx_valid, 0);

        // 4b: accept on the exact load cycle -> no overrun
        ov_cnt = 0;
        send_frame(1'b0, 8'h11, 1'b1, 1'b0);
        check("t4b_first", rx_data, 8'h11);
        fork
            send_frame(1'b0, 8'h22, 1'b1, 1'b0);
            begin
                repeat (154) @(negedge clk);
                rx_ready = 1'b1;
                @(negedge clk);
                rx_ready = 1'b0;
            end
        join
        repeat (4) @(negedge clk);
        check("t4b_data", rx_data, 8'h22);
        check("t4b_valid", rx_valid, 1);
        check("t4b_no_overrun", ov_cnt, 0);

        // 5: reset during data bit 4 of 0xFF, then 0x3C
        fork
            send_frame(1'b0, 8'hFF, 1'b1, 1'b0);
            begin
                repeat (88) @(negedge clk);
                check("t5_busy_before", busy, 1);
                rst = 1'b1;
                #1;
                check("t5_rst_valid", rx_valid, 0);
                check("t5_rst_data", rx_data, 8'h00);
                check("t5_rst_busy", busy, 0);
                repeat (2) @(negedge clk);
                rst = 1'b0;
            end
        join
        repeat (20) @(negedge clk);
        check("t5_no_spurious", rx_valid, 0);
        fe_cnt = 0; ov_cnt = 0;
        send_frame(1'b0, 8'h3C, 1'b1, 1'b0);
        repeat (4) @(negedge clk);
        check("t5_data", rx_data, 8'h3C);
        check("t5_valid", rx_valid, 1);
        check("t5_errs", fe_cnt + ov_cnt, 0);

        // 6: CLKS_PER_BIT=5 with +/-1 clk jitter
        fe5_cnt = 0; ov5_cnt = 0;
        send_frame(1'b1, 8'h00, 1'b1, 1'b1);
        repeat (4) @(negedge clk);
        check("t6_valid0", rx_valid5, 1);
        check("t6_data0", rx_data5, 8'h00);
        rx_ready5 = 1'b1;
        @(negedge clk);
        rx_ready5 = 1'b0;
        check("t6_accept0", rx_valid5, 0);
        send_frame(1'b1, 8'hFF, 1'b1, 1'b1);
        repeat (4) @(negedge clk);
        check("t6_validF", rx_valid5, 1);
        check("t6_dataF", rx_data5, 8'hFF);
        check("t6_errs", fe5_cnt + ov5_cnt, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
